// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Constants shared by the PS/2 front end, the option selector
//                and the player controllers: direction event codes, the scan
//                code set 2 values used by the game, and the receiver state
//                type. Also provides the make-code to player/direction lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Direction event codes carried on direction_1 / direction_2
    localparam logic [2:0] UP    = 3'd0;
    localparam logic [2:0] DOWN  = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] RIGHT = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BOMB  = 3'd5;

    // Scan code set 2 values
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;   // E0-prefixed
    localparam logic [7:0] SC_DOWN  = 8'h72;   // E0-prefixed
    localparam logic [7:0] SC_LEFT  = 8'h6B;   // E0-prefixed
    localparam logic [7:0] SC_RIGHT = 8'h74;   // E0-prefixed

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Result of looking up a scan code: hit=0 means the code is ignored.
    // player=0 is player 1, player=1 is player 2.
    typedef struct packed {
        logic       hit;
        logic       player;
        logic [2:0] dir;
    } key_evt_t;

    function automatic key_evt_t map_key(input logic [7:0] code, input logic ext);
        key_evt_t e;
        e = '{hit: 1'b0, player: 1'b0, dir: STOP};
        if (!ext) begin
            case (code)
                SC_W:     e = '{hit: 1'b1, player: 1'b0, dir: UP};
                SC_S:     e = '{hit: 1'b1, player: 1'b0, dir: DOWN};
                SC_A:     e = '{hit: 1'b1, player: 1'b0, dir: LEFT};
                SC_D:     e = '{hit: 1'b1, player: 1'b0, dir: RIGHT};
                SC_SPACE: e = '{hit: 1'b1, player: 1'b0, dir: BOMB};
                SC_ENTER: e = '{hit: 1'b1, player: 1'b1, dir: BOMB};
                default:  e = '{hit: 1'b0, player: 1'b0, dir: STOP};
            endcase
        end else begin
            case (code)
                SC_UP:    e = '{hit: 1'b1, player: 1'b1, dir: UP};
                SC_DOWN:  e = '{hit: 1'b1, player: 1'b1, dir: DOWN};
                SC_LEFT:  e = '{hit: 1'b1, player: 1'b1, dir: LEFT};
                SC_RIGHT: e = '{hit: 1'b1, player: 1'b1, dir: RIGHT};
                default:  e = '{hit: 1'b0, player: 1'b0, dir: STOP};
            endcase
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host byte receiver. Synchronizes the raw
//                PS/2 clock/data, detects falling edges of the PS/2 clock and
//                shifts in 11-bit frames (start, 8 data LSB first, parity,
//                stop). Abandons a partial frame after TIMEOUT_CYC cycles
//                without a PS/2 clock falling edge.
//  Config      : PS2_PARITY_CHECK_EN - when defined, odd parity is enforced.
//  Ports       : clk, rst (async, active-high)
//                ps2_clk, ps2_data  raw asynchronous PS/2 lines
//                byte_valid         1-cycle strobe, byte_data is valid
//                byte_data[7:0]     received byte
//                frame_err          1-cycle strobe, frame dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Synchronizers reset to 1 so an idle (high) bus never looks like an edge
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       fall_q;
    logic       data_s_q;
    logic       fall_w;

    rx_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
    logic       parity_q, parity_d;
`endif

    assign fall_w = clk_prev_q & ~clk_sync_q[1];

    // Edge-detect stage also delays the data sample so both stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_s_q    <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            fall_q      <= fall_w;
            data_s_q    <= data_sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            cnt_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
`endif
        if (state_q == RX_IDLE) begin
            cnt_d = '0;
            if (fall_q && !data_s_q) begin
                state_d   = RX_DATA;
                bit_cnt_d = 3'd0;
            end
        end else if (fall_q) begin
            cnt_d = '0;
            case (state_q)
                RX_DATA: begin
                    shift_d   = {data_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_s_q;
`endif
                    state_d  = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    if (data_s_q && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                    frame_err_d  = 1'b1;
`else
                    if (data_s_q) byte_valid_d = 1'b1;
                    else          frame_err_d  = 1'b1;
`endif
                end
            endcase
        end else if (cnt_q == CNT_LAST) begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
            cnt_d       = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Turns the PS/2 scan code set 2 stream into per-player
//                direction events. Player 1: W/A/S/D + Space (bomb).
//                Player 2: arrow keys + Enter (bomb). Tracks held keys so
//                typematic repeats produce no extra events.
//  Config      : PS2_PARITY_CHECK_EN - enables odd parity check in ps2_rx.
//  Ports       : clk, rst (async, active-high)
//                ps2_clk, ps2_data         raw PS/2 lines
//                direction_1, in_valid_1   player 1 event + 1-cycle qualifier
//                direction_2, in_valid_2   player 2 event + 1-cycle qualifier
//                rx_err                    1-cycle pulse on dropped frame
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] direction_1,
    output logic       in_valid_1,
    output logic [2:0] direction_2,
    output logic       in_valid_2,
    output logic       rx_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Index 0 is player 1, index 1 is player 2
    logic            e0_seen_q, e0_seen_d;
    logic            f0_seen_q, f0_seen_d;
    logic [1:0][2:0] held_q, held_d;
    logic [1:0]      bomb_held_q, bomb_held_d;
    logic [1:0][2:0] dir_q, dir_d;
    logic [1:0]      valid_q, valid_d;
    logic            rx_err_q, rx_err_d;
    key_evt_t        evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_seen_q   <= 1'b0;
            f0_seen_q   <= 1'b0;
            held_q      <= {STOP, STOP};
            bomb_held_q <= 2'b00;
            dir_q       <= {STOP, STOP};
            valid_q     <= 2'b00;
            rx_err_q    <= 1'b0;
        end else begin
            e0_seen_q   <= e0_seen_d;
            f0_seen_q   <= f0_seen_d;
            held_q      <= held_d;
            bomb_held_q <= bomb_held_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    always_comb begin
        e0_seen_d   = e0_seen_q;
        f0_seen_d   = f0_seen_q;
        held_d      = held_q;
        bomb_held_d = bomb_held_q;
        dir_d       = dir_q;
        valid_d     = 2'b00;
        rx_err_d    = frame_err;
        evt         = map_key(byte_data, e0_seen_q);

        if (byte_valid) begin
            if (byte_data == SC_EXT) begin
                e0_seen_d = 1'b1;
            end else if (byte_data == SC_BREAK) begin
                f0_seen_d = 1'b1;
            end else begin
                e0_seen_d = 1'b0;
                f0_seen_d = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (evt.hit && (evt.player == 1'(p))) begin
                        if (evt.dir == BOMB) begin
                            if (f0_seen_q) begin
                                bomb_held_d[p] = 1'b0;
                            end else if (!bomb_held_q[p]) begin
                                bomb_held_d[p] = 1'b1;
                                dir_d[p]       = BOMB;
                                valid_d[p]     = 1'b1;
                            end
                        end else if (!f0_seen_q) begin
                            // Same key again is a typematic repeat: stay quiet
                            if (evt.dir != held_q[p]) begin
                                held_d[p]  = evt.dir;
                                dir_d[p]   = evt.dir;
                                valid_d[p] = 1'b1;
                            end
                        end else if (evt.dir == held_q[p]) begin
                            // Releasing a key other than the held one is ignored
                            held_d[p]  = STOP;
                            dir_d[p]   = STOP;
                            valid_d[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign direction_1 = dir_q[0];
    assign in_valid_1  = valid_q[0];
    assign direction_2 = dir_q[1];
    assign in_valid_2  = valid_q[1];
    assign rx_err      = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Self-checking bench for ps2_key_decoder. Drives PS/2 frames,
//                predicts the events from a scan-code level model of the key
//                rules and compares pulse counts and direction values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int TO_CYC = 300;
    localparam int HALF   = 6;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] direction_1;
    logic       in_valid_1;
    logic [2:0] direction_2;
    logic       in_valid_2;
    logic       rx_err;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .direction_1 (direction_1),
        .in_valid_1  (in_valid_1),
        .direction_2 (direction_2),
        .in_valid_2  (in_valid_2),
        .rx_err      (rx_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Cumulative pulse-cycle counts; written only by this monitor
    int         cnt1 = 0, cnt2 = 0, cnt_err = 0;
    logic [2:0] last1 = 3'd4, last2 = 3'd4;

    always @(negedge clk) begin
        if (in_valid_1) begin cnt1++; last1 = direction_1; end
        if (in_valid_2) begin cnt2++; last2 = direction_2; end
        if (rx_err)     cnt_err++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // ---------------- reference model (scan-code level) ----------------
    bit m_e0, m_f0;
    int m_held[2];
    bit m_bomb[2];

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0;
        m_held[0] = 4; m_held[1] = 4;
        m_bomb[0] = 0; m_bomb[1] = 0;
    endtask

    // kind: 0 none, 1 player-1 pulse, 2 player-2 pulse
    task automatic model_byte(input logic [7:0] b, output int kind, output int dir);
        int pl, d;
        kind = 0; dir = 0;
        if (b == 8'hE0) m_e0 = 1;
        else if (b == 8'hF0) m_f0 = 1;
        else begin
            pl = -1; d = 0;
            if (!m_e0) begin
                case (b)
                    8'h1D: begin pl = 0; d = 0; end
                    8'h1B: begin pl = 0; d = 1; end
                    8'h1C: begin pl = 0; d = 2; end
                    8'h23: begin pl = 0; d = 3; end
                    8'h29: begin pl = 0; d = 5; end
                    8'h5A: begin pl = 1; d = 5; end
                    default: pl = -1;
                endcase
            end else begin
                case (b)
                    8'h75: begin pl = 1; d = 0; end
                    8'h72: begin pl = 1; d = 1; end
                    8'h6B: begin pl = 1; d = 2; end
                    8'h74: begin pl = 1; d = 3; end
                    default: pl = -1;
                endcase
            end
            if (pl >= 0) begin
                if (d == 5) begin
                    if (m_f0) m_bomb[pl] = 0;
                    else if (!m_bomb[pl]) begin m_bomb[pl] = 1; kind = pl + 1; dir = 5; end
                end else if (!m_f0) begin
                    if (m_held[pl] != d) begin m_held[pl] = d; kind = pl + 1; dir = d; end
                end else if (m_held[pl] == d) begin
                    m_held[pl] = 4; kind = pl + 1; dir = 4;
                end
            end
            m_e0 = 0; m_f0 = 0;
        end
    endtask

    // ---------------- PS/2 line driver ----------------
    task automatic ps2_bit(input bit b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
    endtask

    // Sends one full frame and checks everything it should (and should not) cause
    task automatic run_frame(input logic [7:0] b, input bit bad_par);
        int s1, s2, se, kind, dir;
        s1 = cnt1; s2 = cnt2; se = cnt_err;
        send_bits(b, bad_par, 11);
        repeat (16) @(posedge clk);
        if (bad_par && PAR_EN) begin
            kind = 3; dir = 0;
        end else begin
            model_byte(b, kind, dir);
        end
        check($sformatf("%02h v1 pulses", b), cnt1 - s1, int'(kind == 1));
        check($sformatf("%02h v2 pulses", b), cnt2 - s2, int'(kind == 2));
        check($sformatf("%02h rx_err pulses", b), cnt_err - se, int'(kind == 3));
        if (kind == 1) check($sformatf("%02h dir1", b), int'(last1), dir);
        if (kind == 2) check($sformatf("%02h dir2", b), int'(last2), dir);
    endtask

    // Key table: 0-4 P1 W S A D Space, 5-9 P2 up down left right Enter,
    // 10 plain 0x74, 11 E0 1D (wrong prefix), 12 unmapped Q
    logic [7:0] key_code [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                                  8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A,
                                  8'h74, 8'h1D, 8'h15};
    bit         key_ext  [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0};

    task automatic key_evt(input int k, input bit brk, input bit bad_last);
        if (key_ext[k]) run_frame(8'hE0, 1'b0);
        if (brk)        run_frame(8'hF0, 1'b0);
        run_frame(key_code[k], bad_last);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, se;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check("reset dir1", int'(direction_1), 4);
        check("reset dir2", int'(direction_2), 4);
        check("reset v1",   int'(in_valid_1), 0);
        check("reset v2",   int'(in_valid_2), 0);
        check("reset err",  int'(rx_err), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Player 1 move, repeat, release
        run_frame(8'h1D, 1'b0);
        check("W dir1 up", int'(last1), 0);
        run_frame(8'h1D, 1'b0);
        key_evt(0, 1'b1, 1'b0);
        check("W release stop", int'(last1), 4);
        // Player 2 arrows
        key_evt(8, 1'b0, 1'b0);
        check("right dir2", int'(last2), 3);
        key_evt(8, 1'b1, 1'b0);
        check("right release", int'(last2), 4);
        key_evt(10, 1'b0, 1'b0);
        // Bomb repeat
        key_evt(4, 1'b0, 1'b0);
        key_evt(4, 1'b0, 1'b0);
        key_evt(4, 1'b1, 1'b0);
        key_evt(4, 1'b0, 1'b0);
        check("bomb dir1", int'(last1), 5);
        // Bad parity on S
        key_evt(1, 1'b0, 1'b1);

        // Timeout: stall after start + 4 data bits
        s1 = cnt1; se = cnt_err;
        send_bits(8'h23, 1'b0, 5);
        repeat (TO_CYC + 20) @(posedge clk);
        check("timeout err", cnt_err - se, 1);
        check("timeout v1", cnt1 - s1, 0);
        run_frame(8'h23, 1'b0);
        check("after timeout dir1", int'(last1), 3);

        // Randomized key activity
        for (int n = 0; n < 70; n++) begin
            key_evt($urandom_range(0, 12), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of a frame
        key_evt(2, 1'b0, 1'b0);
        s1 = cnt1;
        send_bits(8'h1B, 1'b0, 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst dir1", int'(direction_1), 4);
        check("midrst dir2", int'(direction_2), 4);
        check("midrst v1",   int'(in_valid_1), 0);
        check("midrst err",  int'(rx_err), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(posedge clk);
        check("midrst no pulse", cnt1 - s1, 0);
        run_frame(8'h1C, 1'b0);
        check("post reset dir1", int'(last1), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
